branch_target_buffer: RTL
=========================

// Module: branch_target_buffer
// PURPOSE
//  Parametrised successor to the execute-stage PC target adder. Computes the
//  E-stage target (PCE + ExtImmE) and mispredict/redirect, and caches resolved
//  taken targets in a direct-mapped BTB. Fetch looks up the BTB by PCF to
//  predict next-PC.
//  Sits between the fetch next-PC mux and the execute-stage branch resolution.
// PARAMETERS
//  XLEN     64  address/immediate width
//  ENTRIES  16  BTB entries; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  TAG_W    10  stored tag bits; PC[TAG_W+IDX_W+1 : IDX_W+2]
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     synchronous active-low reset
//  PCF          in   XLEN  fetch PC to look up
//  PredHitF     out  1     valid tag match at PCF index
//  PredTakenF   out  1     predict taken
//  PredTargetF  out  XLEN  predicted target (0 when !PredHitF)
//  InvalidateAll in  1     fence.i: clear all valid bits
//  UpdateE      in   1     branch/jump resolved in E this cycle
//  PCE          in   XLEN  execute-stage PC
//  ExtImmE      in   XLEN  sign-extended immediate
//  TakenE       in   1     actual outcome (1 for jal)
//  PredTakenE   in   1     PredTakenF piped to E
//  PredTargetE  in   XLEN  PredTargetF piped to E
//  PCTargetE    out  XLEN  PCE + ExtImmE, modulo 2^XLEN
//  MispredictE  out  1     UpdateE & (TakenE!=PredTakenE | TakenE & PredTargetE!=PCTargetE)
//  RedirectPCE  out  XLEN  TakenE ? PCTargetE : PCE+4
// BEHAVIOUR
//  - State: valid[ENTRIES], tag[], target[], ctr[] (2-bit). Outputs are
//    combinational from state + inputs; F lookup = async read, 0-cycle.
//  - Reset (rst_n=0 at edge): all valid=0, ctr=2'b01. Outputs then:
//    PredHitF=0, PredTakenF=0, PredTargetF=0; E outputs purely combinational.
//  - Index = PC[IDX_W+1:2]; PC[1:0] ignored (no C-ext).
//  - Update (edge, UpdateE=1), idx/tag from PCE, hitE = valid&tag match:
//    TakenE & !hitE : allocate/overwrite: valid=1, tag, target=PCTargetE, ctr=2'b10
//    TakenE & hitE  : target=PCTargetE, ctr saturating +1 (max 11)
//    !TakenE & hitE : ctr saturating -1 (min 00)
//    !TakenE & !hitE: no change
//  - Same-cycle F lookup and E update of same index: F sees OLD contents.
//  - InvalidateAll & UpdateE same edge: invalidate wins; all valid=0.
//  - InvalidateAll does not reset ctr/tag/target.
//  - rst_n low mid-update: reset wins; no write.
//  - MispredictE/RedirectPCE meaningful only when UpdateE=1; MispredictE=0 otherwise.
//  - PCE+4 and PCTargetE wrap at 2^XLEN, no overflow flag.
// CONFIGURATION
//  BTB_BIMODAL_EN defined : PredTakenF = PredHitF & ctr[idx][1].
//  Undefined : no ctr storage; PredTakenF = PredHitF; !TakenE & hitE clears
//   valid (entry evicted); ctr rules above ignored.
// STRUCTURE
//  Package riscv_btb_pkg: btb_entry_t {valid, tag, target}, ctr_t (logic[1:0]),
//   CTR_WNT=2'b01, CTR_WT=2'b10, function btb_idx()/btb_tag().
//  Sub-module btb_sat_ctr: 2-bit saturating inc/dec, instanced per entry
//   only under BTB_BIMODAL_EN.
// TESTING
//  1 reset, PCF=0x1000 -> PredHitF=0, PredTakenF=0, PredTargetF=0.
//  2 UpdateE, PCE=0x1000, ExtImmE=0x40, TakenE=1, PredTakenE=0 ->
//    PCTargetE=0x1040, MispredictE=1, RedirectPCE=0x1040; next cycle
//    PCF=0x1000 -> PredHitF=1, PredTakenF=1, PredTargetF=0x1040.
//  3 after 2: PCF=0x1000+ENTRIES*4 (alias, tag differs) -> PredHitF=0.
//  4 PCE=0x1000, ExtImmE=-8 (0xFFFF_FFFF_FFFF_FFF8), TakenE=0, PredTakenE=1,
//    PredTargetE=0x0FF8 -> MispredictE=1, RedirectPCE=0x1004; bimodal: ctr 10->01,
//    PredTakenF=0 next; non-bimodal: PredHitF=0 next.
//  5 PCE=0xFFFF_FFFF_FFFF_FFFC, ExtImmE=8 -> PCTargetE=0x4; RedirectPCE (not taken)=0x0.
//  6 InvalidateAll with UpdateE TakenE same cycle -> all PredHitF=0 next cycle;
//    same-cycle F/E same index -> F returns pre-update data.

Source files
------------

// File: rtl/riscv_btb_pkg.sv
// ============================================================================
// Module      : riscv_btb_pkg
// Description : Shared types, counter encodings and index/tag helpers for the
//               branch target buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Default geometry, used only for the reference entry layout below.
  localparam int unsigned BTB_DEF_XLEN  = 64;
  localparam int unsigned BTB_DEF_TAG_W = 10;

  typedef struct packed {
    logic                     valid;
    logic [BTB_DEF_TAG_W-1:0] tag;
    logic [BTB_DEF_XLEN-1:0]  target;
  } btb_entry_t;

  // Helpers take a PC zero-extended to the widest supported address width so
  // that they serve any XLEN up to PC_MAX_W.
  localparam int unsigned PC_MAX_W = 128;
  typedef logic [PC_MAX_W-1:0] pc_max_t;

  function automatic logic [31:0] btb_idx(input pc_max_t pc, input int unsigned idx_w);
    pc_max_t mask;
    mask = (pc_max_t'(1) << idx_w) - pc_max_t'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [63:0] btb_tag(input pc_max_t pc, input int unsigned idx_w,
                                          input int unsigned tag_w);
    pc_max_t mask;
    mask = (pc_max_t'(1) << tag_w) - pc_max_t'(1);
    return 64'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_sat_ctr.sv
// ============================================================================
// Module      : btb_sat_ctr
// Description : 2-bit saturating up/down counter with synchronous load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_sat_ctr
  import riscv_btb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  ctr_t i_load_val,
  input  logic i_inc,
  input  logic i_dec,
  output ctr_t o_ctr
);

  ctr_t ctr_q;
  ctr_t ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (i_load) begin
      ctr_d = i_load_val;
    end else if (i_inc && (ctr_q != CTR_ST)) begin
      ctr_d = ctr_q + 2'b01;
    end else if (i_dec && (ctr_q != CTR_SNT)) begin
      ctr_d = ctr_q - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q <= CTR_WNT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign o_ctr = ctr_q;

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module      : branch_target_buffer
// Description : E-stage target/mispredict/redirect plus a direct-mapped BTB
//               looked up asynchronously by the fetch PC. Define
//               BTB_BIMODAL_EN to add per-entry 2-bit direction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer
  import riscv_btb_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PCF,
  output logic            PredHitF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            InvalidateAll,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ExtImmE,
  input  logic            TakenE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_f;
  logic             hit_e;
  logic [XLEN-1:0]  pc_plus4_e;

  // Write enables; an invalidate in the same cycle suppresses any write.
  logic wr_en;
  logic alloc_en;
  logic hit_taken_en;
  logic hit_not_taken_en;

  // ---------------------------------------------------------------------------
  // Index / tag extraction
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_f = IDX_W'(btb_idx(pc_max_t'(PCF), IDX_W));
    idx_e = IDX_W'(btb_idx(pc_max_t'(PCE), IDX_W));
    tag_f = TAG_W'(btb_tag(pc_max_t'(PCF), IDX_W, TAG_W));
    tag_e = TAG_W'(btb_tag(pc_max_t'(PCE), IDX_W, TAG_W));
  end

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // ---------------------------------------------------------------------------
  // Execute-stage resolution
  // ---------------------------------------------------------------------------
  assign PCTargetE  = PCE + ExtImmE;
  assign pc_plus4_e = PCE + XLEN'(4);

  always_comb begin
    RedirectPCE = TakenE ? PCTargetE : pc_plus4_e;
    MispredictE = UpdateE &&
                  ((TakenE != PredTakenE) || (TakenE && (PredTargetE != PCTargetE)));
  end

  assign wr_en            = UpdateE && !InvalidateAll;
  assign alloc_en         = wr_en && TakenE && !hit_e;
  assign hit_taken_en     = wr_en && TakenE && hit_e;
  assign hit_not_taken_en = wr_en && !TakenE && hit_e;

  // ---------------------------------------------------------------------------
  // Entry next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;

    if (alloc_en) begin
      valid_d[idx_e]  = 1'b1;
      tag_d[idx_e]    = tag_e;
      target_d[idx_e] = PCTargetE;
    end else if (hit_taken_en) begin
      target_d[idx_e] = PCTargetE;
    end
`ifndef BTB_BIMODAL_EN
    // Without direction counters a resolved not-taken hit evicts the entry.
    if (hit_not_taken_en) begin
      valid_d[idx_e] = 1'b0;
    end
`endif

    if (InvalidateAll) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch-stage prediction
  // ---------------------------------------------------------------------------
  assign PredHitF    = hit_f;
  assign PredTargetF = hit_f ? target_q[idx_f] : '0;

`ifdef BTB_BIMODAL_EN
  ctr_t ctr [ENTRIES];

  generate
    for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
      logic sel;
      assign sel = (idx_e == IDX_W'(g));

      btb_sat_ctr u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (alloc_en && sel),
        .i_load_val (CTR_WT),
        .i_inc      (hit_taken_en && sel),
        .i_dec      (hit_not_taken_en && sel),
        .o_ctr      (ctr[g])
      );
    end
  endgenerate

  assign PredTakenF = hit_f && ctr[idx_f][1];
`else
  assign PredTakenF = hit_f;
`endif

endmodule

`default_nettype wire
